reg_file_mp: RTL
================

Name: reg_file_mp

Overview:
- Parametrised multi-port register file, successor to the single-write/two-read pipeline register file.
- Sits in the ID stage and is written from WB.
- Adds configurable read-port count, two prioritised write ports and a per-register pending scoreboard for multi-cycle producers.
- Adds a sequenced soft-clear engine so the pipeline can flush architectural state without a global reset.

Parameters:
- WIDTH, 32, data width in bits.
- NREG, 32, number of registers (power of two, >=4); register 0 is hard-wired zero.
- NRD, 2, number of read ports (1..4).
- AW, $clog2(NREG), address width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- raddr  in  NRD*AW  read addresses; port k at bits [k*AW +: AW].
- rdata  out  NRD*WIDTH  read data; port k at bits [k*WIDTH +: WIDTH].
- rbusy  out  NRD  port k's register has a pending producer.
- we0  in  1  write enable, port 0 (ALU writeback).
- waddr0  in  AW  write address, port 0.
- wdata0  in  WIDTH  write data, port 0.
- we1  in  1  write enable, port 1 (load/MDU writeback).
- waddr1  in  AW  write address, port 1.
- wdata1  in  WIDTH  write data, port 1.
- sb_set  in  1  mark sb_addr pending (multi-cycle op issued).
- sb_addr  in  AW  scoreboard set address.
- clr_req  in  1  single-cycle request to zero all registers.
- clr_busy  out  1  clear sequence in progress; pipeline must stall.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset (rst=1 at a clk edge):
  - All registers become 0, all scoreboard bits become 0, FSM goes to IDLE, clr_busy=0.
  - Reset overrides every other input, including an in-flight clear.
- Reads are combinational:
  - rdata[k] = 0 when raddr[k]==0, otherwise the stored value.
  - rbusy[k] = scoreboard bit of raddr[k]; it is always 0 for address 0.
- Writes commit at the rising edge when weN=1 and waddrN!=0.
  - Both ports writing the same address: port 1 wins.
  - Writes to address 0 are discarded.
- Scoreboard:
  - sb_set sets bit[sb_addr] at the edge; ignored for address 0.
  - Any committed write (either port) clears bit[waddr].
  - Set and clear of the same address in the same cycle: set wins, because it is a new producer.
- Clear FSM:
  - States are IDLE and CLEAR.
  - IDLE & clr_req: go to CLEAR, load cnt=1, clear all scoreboard bits that same edge.
  - Each CLEAR cycle writes 0 to reg[cnt], then cnt+=1. When cnt==NREG-1 is written, return to IDLE.
  - clr_busy=1 exactly while in CLEAR, for NREG-1 cycles.
  - While in CLEAR: we0, we1 and sb_set are ignored, and clr_req is ignored (no restart).
  - Reads during CLEAR return current contents; registers already cleared read 0.
- Width rules:
  - cnt is AW bits wide; no wrap, since termination is at NREG-1.
  - NRD out of range is a parameter error, enforced by an elaboration-time check.

Optional Feature:
- Macro: REG_FILE_MP_BYPASS_EN.
- Defined: write-to-read forwarding.
  - rdata[k] returns wdata of a same-cycle write to raddr[k] (port 1 over port 0, never for address 0).
  - rbusy[k] is forced 0 when such a write hits raddr[k] and sb_set does not target it.
  - Forwarding is disabled while clr_busy=1.
- Undefined: reads see only committed state; the consumer waits one extra cycle after writeback.

Decomposition:
- Shared package regfile_pkg holds:
  - defaults REG_WIDTH=32 and REG_NUM=32;
  - REG_ZERO address constant;
  - clear-FSM state enum {CLR_IDLE, CLR_ACTIVE}.
- One natural sub-module: reg_file_mp_rdport.
  - One instance per read port, generated NRD times.
  - Contains the zero-mux and the optional bypass compare.

Test Plan:
1. Reset, write 0xDEADBEEF to r5 via port 0, read r5 on both ports next cycle -> 0xDEADBEEF on each; read r0 -> 0.
2. Same cycle: we0 (r7, 0x1111) and we1 (r7, 0x2222) -> r7 = 0x2222 next cycle.
3. sb_set r9 -> rbusy=1 for r9; 3 cycles later we1 r9 = 0x55 -> rbusy=0 and rdata=0x55; sb_set and write to r9 in the same cycle -> rbusy stays 1.
4. Fill r1..r31 with nonzero values, pulse clr_req -> clr_busy high exactly 31 cycles; a we0 during clear is dropped; afterwards all registers read 0 and all rbusy are 0.
5. rst asserted at cycle 10 of a clear -> next cycle clr_busy=0 and all registers read 0.
6. With REG_FILE_MP_BYPASS_EN: we0 r3 = 0xA5A5 with raddr0=r3 in the same cycle -> rdata0 = 0xA5A5 that cycle; without the macro -> old value that cycle, 0xA5A5 the next.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

  localparam int REG_WIDTH = 32;
  localparam int REG_NUM   = 32;

  // Architectural zero register; reads as 0, writes and pending marks discarded.
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [0:0] {
    CLR_IDLE   = 1'b0,
    CLR_ACTIVE = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_file_mp_rdport.sv
// One read port: zero-register mux and, with REG_FILE_MP_BYPASS_EN, same-cycle
// write-to-read forwarding (port 1 over port 0).
module reg_file_mp_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH,
  parameter int AW    = 5
) (
  input  logic [AW-1:0]    raddr_i,
  input  logic [WIDTH-1:0] rf_data_i,
  input  logic             sb_bit_i,
  input  logic             fwd_en_i,
  input  logic             we0_i,
  input  logic [AW-1:0]    waddr0_i,
  input  logic [WIDTH-1:0] wdata0_i,
  input  logic             we1_i,
  input  logic [AW-1:0]    waddr1_i,
  input  logic [WIDTH-1:0] wdata1_i,
  input  logic             sb_set_i,
  input  logic [AW-1:0]    sb_addr_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rbusy_o
);

`ifdef REG_FILE_MP_BYPASS_EN
  logic hit0_s;
  logic hit1_s;
  logic set_hit_s;

  assign hit0_s    = fwd_en_i && we0_i && (waddr0_i == raddr_i);
  assign hit1_s    = fwd_en_i && we1_i && (waddr1_i == raddr_i);
  assign set_hit_s = sb_set_i && (sb_addr_i == raddr_i);

  // A forwarded write retires the pending mark unless a new producer claims the register.
  always_comb begin
    rdata_o = rf_data_i;
    rbusy_o = sb_bit_i;
    if (raddr_i == AW'(REG_ZERO)) begin
      rdata_o = '0;
      rbusy_o = 1'b0;
    end else if (hit1_s) begin
      rdata_o = wdata1_i;
      rbusy_o = set_hit_s ? sb_bit_i : 1'b0;
    end else if (hit0_s) begin
      rdata_o = wdata0_i;
      rbusy_o = set_hit_s ? sb_bit_i : 1'b0;
    end else begin
      rdata_o = rf_data_i;
      rbusy_o = sb_bit_i;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{fwd_en_i, we0_i, waddr0_i, wdata0_i, we1_i, waddr1_i,
                      wdata1_i, sb_set_i, sb_addr_i};

  // Committed state only.
  always_comb begin
    rdata_o = rf_data_i;
    rbusy_o = sb_bit_i;
    if (raddr_i == AW'(REG_ZERO)) begin
      rdata_o = '0;
      rbusy_o = 1'b0;
    end else begin
      rdata_o = rf_data_i;
      rbusy_o = sb_bit_i;
    end
  end
`endif

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with prioritised writes, pending scoreboard and a
// sequenced soft-clear engine. Optional forwarding: REG_FILE_MP_BYPASS_EN.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH = REG_WIDTH,
  parameter  int NREG  = REG_NUM,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*WIDTH-1:0] rdata,
  output logic [NRD-1:0]       rbusy,
  input  logic                 we0,
  input  logic [AW-1:0]        waddr0,
  input  logic [WIDTH-1:0]     wdata0,
  input  logic                 we1,
  input  logic [AW-1:0]        waddr1,
  input  logic [WIDTH-1:0]     wdata1,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  input  logic                 clr_req,
  output logic                 clr_busy
);

  if (NRD < 1 || NRD > 4) begin : g_nrd_check
    $error("reg_file_mp: NRD must be in 1..4");
  end
  if (NREG < 4 || (NREG & (NREG - 1)) != 0) begin : g_nreg_check
    $error("reg_file_mp: NREG must be a power of two >= 4");
  end

  clr_state_e       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [NREG-1:0]  sb_q, sb_d;
  logic             clr_busy_q;

  logic idle_s, clr_start_s, wr0_s, wr1_s, set_s;

  assign idle_s      = (state_q == CLR_IDLE);
  assign clr_start_s = idle_s && clr_req;
  assign wr0_s       = idle_s && we0 && (waddr0 != AW'(REG_ZERO));
  assign wr1_s       = idle_s && we1 && (waddr1 != AW'(REG_ZERO));
  assign set_s       = idle_s && sb_set && (sb_addr != AW'(REG_ZERO));
  assign clr_busy    = clr_busy_q;

  // Clear sequencer: walk cnt from 1 to NREG-1, one register per cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_ACTIVE;
          cnt_d   = AW'(1);
        end else begin
          state_d = CLR_IDLE;
          cnt_d   = cnt_q;
        end
      end
      CLR_ACTIVE: begin
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = CLR_IDLE;
          cnt_d   = cnt_q;
        end else begin
          state_d = CLR_ACTIVE;
          cnt_d   = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = CLR_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Register and scoreboard next state; port 1 beats port 0, a new producer beats retirement.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      if (i == 0) begin
        regs_d[i] = '0;
        sb_d[i]   = 1'b0;
      end else begin
        if (!idle_s && cnt_q == AW'(i)) begin
          regs_d[i] = '0;
        end else if (wr1_s && waddr1 == AW'(i)) begin
          regs_d[i] = wdata1;
        end else if (wr0_s && waddr0 == AW'(i)) begin
          regs_d[i] = wdata0;
        end else begin
          regs_d[i] = regs_q[i];
        end

        if (clr_start_s) begin
          sb_d[i] = 1'b0;
        end else if (set_s && sb_addr == AW'(i)) begin
          sb_d[i] = 1'b1;
        end else if ((wr0_s && waddr0 == AW'(i)) || (wr1_s && waddr1 == AW'(i))) begin
          sb_d[i] = 1'b0;
        end else begin
          sb_d[i] = sb_q[i];
        end
      end
    end
  end

  // State registers with synchronous reset overriding any in-flight clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLR_IDLE;
      cnt_q      <= '0;
      sb_q       <= '0;
      clr_busy_q <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sb_q       <= sb_d;
      clr_busy_q <= (state_d == CLR_ACTIVE);
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    reg_file_mp_rdport #(
      .WIDTH(WIDTH),
      .AW   (AW)
    ) u_rdport (
      .raddr_i  (raddr[k*AW +: AW]),
      .rf_data_i(regs_q[raddr[k*AW +: AW]]),
      .sb_bit_i (sb_q[raddr[k*AW +: AW]]),
      .fwd_en_i (idle_s),
      .we0_i    (we0),
      .waddr0_i (waddr0),
      .wdata0_i (wdata0),
      .we1_i    (we1),
      .waddr1_i (waddr1),
      .wdata1_i (wdata1),
      .sb_set_i (sb_set),
      .sb_addr_i(sb_addr),
      .rdata_o  (rdata[k*WIDTH +: WIDTH]),
      .rbusy_o  (rbusy[k])
    );
  end

endmodule
